// File: rtl/setbit_result_fifo.sv
// setbit_result_fifo: result/status FIFO with saturating error count; define SETBIT_RESULT_FIFO_DROP_ERR_EN to discard error pairs
module setbit_result_fifo #(
    parameter int NUM   = 4,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [NUM-1:0]             i_result,
    input  logic [NUM-1:0]             i_status,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic [NUM-1:0]             o_result,
    output logic [NUM-1:0]             o_status,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic [7:0]                 o_err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [AW-1:0]    wp, rp;
    logic [2*NUM-1:0] mem [DEPTH];
    logic             push, pop, store, err;
    always_comb begin
        o_ready = (o_count != CW'(DEPTH)) && !i_rst;
        o_valid = o_count != '0;
        push    = i_valid && o_ready;
        pop     = o_valid && i_ready && !i_rst;
        err     = i_status != '0;
`ifdef SETBIT_RESULT_FIFO_DROP_ERR_EN
        store   = push && !err;
`else
        store   = push;
`endif
        {o_result, o_status} = o_valid ? mem[rp] : '0;
    end
    always_ff @(posedge i_clk)
        if (store)
            mem[wp] <= {i_result, i_status};
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp        <= '0;
            rp        <= '0;
            o_count   <= '0;
            o_err_cnt <= '0;
        end else begin
            if (store)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            o_count <= o_count + CW'(store) - CW'(pop);
            if (push && err && o_err_cnt != 8'hff)
                o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
endmodule

// File: doc/setbit_result_fifo.md
# setbit_result_fifo

Output buffer directly downstream of the `setbit` combinational stage. Captures each `o_result`/`o_status` pair produced by `setbit` under a valid/ready handshake and stores it in a small FIFO. Presents stored pairs to the next consumer in order, and maintains a saturating count of error-status results. It decouples the combinational bit-set datapath from a consumer that may stall.

## Interface
- `NUM`, default 4: data width; matches `setbit` `NUM`.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_valid`  in  1: upstream pair on `i_result`/`i_status` is valid.
- `i_result`  in  NUM: result from `setbit` `o_result`.
- `i_status`  in  NUM: status from `setbit` `o_status`; nonzero means error.
- `o_ready`  out  1: FIFO can accept a pair this cycle.
- `o_valid`  out  1: head entry available.
- `o_result`  out  NUM: head entry result.
- `o_status`  out  NUM: head entry status.
- `i_ready`  in  1: downstream accepts head entry this cycle.
- `o_count`  out  $clog2(DEPTH+1): current occupancy.
- `o_err_cnt`  out  8: number of accepted pairs with nonzero status, saturating.

## Operation
- **Push:** occurs when `i_valid && o_ready`. Writes `{i_result, i_status}` at the write pointer, then increments the write pointer.
- **Pop:** occurs when `o_valid && i_ready`. Increments the read pointer.
- **Pointers:** wrap modulo `DEPTH`.
- **`o_ready`:** equals `!full && !i_rst`. It is combinational from occupancy only and never depends on `i_ready`. There is no bypass when full.
- **`o_valid`:** equals `count != 0`.
- **Empty outputs:** when empty, `o_result` and `o_status` drive all-zero.
- **Simultaneous push and pop (non-empty, non-full):** both occur and `o_count` is unchanged.
- **Full:** a push is impossible because `o_ready` is 0. A pop in the full state lowers `o_count` to `DEPTH-1`, and `o_ready` goes to 1 on the following cycle.
- **Empty:** a pop is impossible because `o_valid` is 0. A push raises `o_count` to 1.
- **`o_err_cnt`:** increments by 1 on every push where `i_status != 0`. It saturates at 255 and never wraps. Pops do not affect it.
- **Ordering:** strict FIFO. Data is never reordered, duplicated or lost while the handshake rules are obeyed.
- **Reset:** clears both pointers, `o_count`, and `o_err_cnt`. Storage contents are not cleared. An entry pushed in the same cycle that `i_rst` is high is discarded.

## Timing
- **Reset values (cycle after reset):** `o_valid=0`, `o_result=0`, `o_status=0`, `o_count=0`, `o_err_cnt=0`, `o_ready=1`.
- **Latency:** one cycle from accepted push to `o_valid`. A pair pushed at edge N is visible on the outputs after edge N.
- **Pop effect:** a popped entry leaves the outputs after the same edge at which it is popped. The next entry, if any, appears immediately.
- **Registered outputs:** `o_count` and `o_err_cnt` are registered and reflect all handshakes up to the last edge.
- **Combinational paths:** `o_result` and `o_status` are a combinational read of the head entry. There is no combinational path from `i_valid` or `i_ready` to any output.
- **Reset mid-operation:** takes effect at the next edge regardless of handshakes in that cycle. Neither a push nor a pop completes in that cycle.

## Configuration
- **`SETBIT_RESULT_FIFO_DROP_ERR_EN` defined:**
  - A pair with `i_status != 0` is still accepted (handshake completes, `o_err_cnt` increments).
  - The pair is not written to the FIFO. Pointers and `o_count` are unchanged, so such pairs never appear on `o_valid`.
- **`SETBIT_RESULT_FIFO_DROP_ERR_EN` undefined:** all accepted pairs are stored and delivered, including error pairs.

## Test plan
- **Reset:** hold `i_rst=1` for 2 cycles with `i_valid=1` → after release, `o_count=0`, `o_valid=0`, `o_err_cnt=0`, `o_ready=1`.
- **Fill and drain (`DEPTH=4`):**
  - Push `{0x1,0}`, `{0x3,0}`, `{0x7,0}`, `{0xF,0}` with `i_ready=0` → `o_count=4`, `o_ready=0`.
  - Then a fifth push with `i_valid=1` holding `{0x8,0}` → ignored.
  - Then `i_ready=1` → outputs 0x1, 0x3, 0x7, 0xF on 4 consecutive cycles, then `o_valid=0`.
- **Simultaneous push/pop:** with 2 entries, push `{0x5,0}` while popping → `o_count` stays 2 and the order is preserved.
- **Pointer wrap:** stream 10 pairs with `i_ready=1` and `i_valid` held high → output sequence identical to input and `o_count` never exceeds 1.
- **Error counting:**
  - 300 pushes of `{0x0,0x1}` with `i_ready=1` → `o_err_cnt=255`.
  - Macro undefined: all 300 entries are delivered.
  - Macro defined: `o_valid` stays 0 throughout.
- **Reset mid-stream:** with 3 entries queued, assert `i_rst` for 1 cycle while pushing and popping → `o_count=0` and no entry is delivered afterward.
